// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if
// Micro-instruction bus feeding the operand stage.
//   in_valid  : a micro-instruction is present on the bus
//   in_ready  : the stage can accept this cycle
//   in_op     : operation select (0..5 legal, 6..7 illegal)
//   in_rs     : source A register
//   in_rt     : source B register
//   in_rd     : destination register
//   in_imm_en : take operand B from in_imm instead of R[in_rt]
//   in_imm    : immediate value
// The master modport is the instruction source, the slave modport is the stage.
interface alu_operand_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8
);
  localparam int AW = $clog2(REG_N);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [AW-1:0]     in_rs;
  logic [AW-1:0]     in_rt;
  logic [AW-1:0]     in_rd;
  logic              in_imm_en;
  logic [DATA_W-1:0] in_imm;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm_en, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm_en, in_imm,
    output in_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Operand-fetch and writeback stage wrapped around an external combinational
// ALU. It reads two operands from an 8-entry register file (with forwarding
// and an optional immediate), registers them with the ALU control into the
// EX stage, and writes the ALU result back one cycle later.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   in_bus            : micro-instruction bus (slave side)
//   stall             : freezes every pipeline register
//   alu_a, alu_b      : registered operands to the ALU
//   alu_ctl           : registered ALU control
//   alu_out, zero     : combinational ALU result and zero flag
//   res_valid         : one-cycle pulse when a result retires
//   res_rd, res_data  : destination and value of the retired result
//   res_zero          : zero flag of the retired result
//   illegal_op        : one-cycle pulse when an illegal op is accepted
//   dbg_addr/dbg_data : combinational debug read of the register file
module alu_operand_stage #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_operand_stage_if.slave         in_bus,
  input  logic                       stall,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [3:0]                 alu_ctl,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic                       zero,
  output logic                       res_valid,
  output logic [$clog2(REG_N)-1:0]   res_rd,
  output logic [DATA_W-1:0]          res_data,
  output logic                       res_zero,
  output logic                       illegal_op,
  input  logic [$clog2(REG_N)-1:0]   dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);
  localparam int AW = $clog2(REG_N);

  logic [DATA_W-1:0] regs [REG_N];
  logic              ex_valid;
  logic [AW-1:0]     ex_rd;
  logic [3:0]        ctl_dec;
  logic              op_legal;
  logic              accept;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign in_bus.in_ready = !stall;
  assign accept          = in_bus.in_valid && !stall;
  assign dbg_data        = regs[dbg_addr];

  // Translate the compact op code into the ALU's 4-bit control word.
  // Codes 6 and 7 have no ALU meaning and are flagged illegal.
  always_comb begin
    ctl_dec  = 4'b0000;
    op_legal = 1'b1;
    case (in_bus.in_op)
      3'd0:    ctl_dec = 4'b0000;
      3'd1:    ctl_dec = 4'b0001;
      3'd2:    ctl_dec = 4'b0010;
      3'd3:    ctl_dec = 4'b0110;
      3'd4:    ctl_dec = 4'b0111;
      3'd5:    ctl_dec = 4'b1100;
      default: op_legal = 1'b0;
    endcase
  end

  // Operand selection. The instruction in EX has not reached the register
  // file yet, so a matching source register takes the live ALU result
  // instead. R0 is never forwarded because it must always read zero, and B
  // is not forwarded when it comes from the immediate.
  always_comb begin
    opnd_a = regs[in_bus.in_rs];
    if (ex_valid && (ex_rd == in_bus.in_rs) && (in_bus.in_rs != '0))
      opnd_a = alu_out;
    opnd_b = regs[in_bus.in_rt];
    if (in_bus.in_imm_en)
      opnd_b = in_bus.in_imm;
    else if (ex_valid && (ex_rd == in_bus.in_rt) && (in_bus.in_rt != '0))
      opnd_b = alu_out;
  end

  // EX register. A legal accept loads operands and control; an illegal
  // accept or an idle cycle inserts a bubble while the operand/control
  // registers keep their last values. Stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctl  <= 4'b0000;
    end else if (!stall) begin
      if (accept && op_legal) begin
        ex_valid <= 1'b1;
        ex_rd    <= in_bus.in_rd;
        alu_a    <= opnd_a;
        alu_b    <= opnd_b;
        alu_ctl  <= ctl_dec;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

  // Register file write port. The result in EX retires on the next
  // unstalled edge; writes to R0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++)
        regs[i] <= '0;
    end else if (ex_valid && !stall && (ex_rd != '0)) begin
      regs[ex_rd] <= alu_out;
    end
  end

  // Retirement reporting. res_valid pulses for every retired result
  // (including R0 destinations); the payload holds between retirements.
  // During a stall the pulses are forced low while the payload holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_rd     <= '0;
      res_data   <= '0;
      res_zero   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (stall) begin
      res_valid  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      res_valid  <= ex_valid;
      illegal_op <= accept && !op_legal;
      if (ex_valid) begin
        res_rd   <= ex_rd;
        res_data <= alu_out;
        res_zero <= zero;
      end
    end
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch and writeback stage wrapped around the 8-bit `mipsALU`. It accepts one micro-instruction per cycle over a valid/ready handshake and reads two operands from an 8-entry register file, with forwarding and an optional immediate. It drives registered `a`, `b` and `alu_ctl` into the ALU, then writes `alu_out` back to the destination register one cycle later. It is the sequential front end that turns the ALU into a usable 2-stage datapath.

## Interface
- `DATA_W`, 8, operand/result width; must match the ALU.
- `REG_N`, 8, register count; address width is `$clog2(REG_N)` (3).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: micro-instruction present.
- `in_ready` out 1: stage can accept; equals `!stall`.
- `in_op` in 3: operation select.
- `in_rs`, `in_rt`, `in_rd` in 3 each: source A, source B and destination register.
- `in_imm_en` in 1: use `in_imm` instead of `R[rt]` for B.
- `in_imm` in 8: immediate.
- `stall` in 1: freezes every pipeline register.
- `alu_a`, `alu_b` out 8: registered operands to the ALU.
- `alu_ctl` out 4: registered ALU control.
- `alu_out` in 8: ALU result (combinational from `alu_a`/`alu_b`/`alu_ctl`).
- `zero` in 1: ALU zero flag.
- `res_valid` out 1: one-cycle pulse when a result retires.
- `res_rd` out 3: destination register of the retired result.
- `res_data` out 8: value of the retired result.
- `res_zero` out 1: zero flag of the retired result.
- `illegal_op` out 1: one-cycle pulse when an illegal op is accepted.
- `dbg_addr` in 3: debug read address.
- `dbg_data` out 8: combinational `R[dbg_addr]`.

## Operation
- **Op map (`in_op` -> `alu_ctl`):**
  - 0 AND -> 0000
  - 1 OR -> 0001
  - 2 ADD -> 0010
  - 3 SUB -> 0110
  - 4 SLT -> 0111
  - 5 NOR -> 1100
  - 6 and 7 are illegal.
- **Accept:** an instruction is accepted when `in_valid && in_ready`.
- **EX register:** on accept it loads `ex_valid=1`, `alu_a`, `alu_b`, `alu_ctl` and `ex_rd`. When `!stall` with no accept, `ex_valid=0` and the operand/control registers hold their values.
- **Illegal op:** accepted but loads `ex_valid=0` (a bubble) and pulses `illegal_op` in the next cycle. Register file is untouched.
- **Operand A:** `R[in_rs]`. **Operand B:** `in_imm_en ? in_imm : R[in_rt]`.
- **Forwarding:** if `ex_valid`, `ex_rd==src`, `src!=0` and the source is a register, the operand is taken from `alu_out` instead of the register file.
- **R0:** always reads 0; writes to it are discarded, but `res_valid` still pulses.
- **Writeback:** on the edge after EX, if `ex_valid && !stall`:
  - `R[ex_rd] <= alu_out` (when `ex_rd!=0`)
  - `res_valid=1`, `res_rd=ex_rd`, `res_data=alu_out`, `res_zero=zero`
  - Otherwise `res_valid=0` and the other `res_*` outputs hold.
- **Arithmetic:** done in the ALU; wrap-around is mod 256. SLT is signed or unsigned as the ALU defines; the bench uses operands < 0x80.
- **Stall:** `stall=1` holds EX, the `res_*` outputs and the register file exactly. `in_ready=0`, no write occurs, and `res_valid` and `illegal_op` are 0 during the stall.

## Timing
- **Reset (async assert, sync-free deassert):**
  - `alu_a=alu_b=0`, `alu_ctl=0000`, `ex_valid=0`
  - `res_valid=0`, `res_rd=0`, `res_data=0`, `res_zero=0`, `illegal_op=0`
  - all `R[i]=0`
  - `in_ready` follows `!stall` immediately.
- **Latency:** accept at edge N -> ALU inputs valid during cycle N..N+1 -> register write and `res_valid` at edge N+1.
- **Throughput:** 1 instruction/cycle. Back-to-back dependents need no bubble because of forwarding.
- **Reset mid-operation:** an in-flight EX instruction is dropped and never written.
- **Simultaneous write and read:** a write to `R[x]` and a new read of `R[x]` in the same cycle resolve through forwarding (the new value). `dbg_data` shows the old value until the edge.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream -> all outputs 0, `dbg_data` for r0..r7 all 0x00, `res_valid` stays 0 after release until a new accept.
- **Immediate ADD and SUB:** ADD r1=r0+imm 0x22, then SUB r2=r1−imm 0x0B back-to-back -> second EX shows `alu_a=0x22` (forwarded), `alu_ctl=0110`; `res_data` 0x22 then 0x17; `dbg` r2=0x17.
- **Op coverage:** preload r3=0x35, r4=0x19, then AND/OR/NOR/SLT r5=r3,r4 -> `res_data` 0x11, 0x3D, 0xC2, 0x00; SLT r5=r4,r3 -> 0x01.
- **Zero and wrap:** SUB r6=r3−r3 -> `res_data=0`, `res_zero=1`. ADD r6=r0+0xFF, then ADD r6=r6+imm 0x02 -> 0x01.
- **R0 and illegal op:** ADD r0=r0+imm 0x07 -> `res_valid=1`, r0 still 0. `in_op=6` -> `illegal_op` pulses one cycle, no `res_valid`, registers unchanged.
- **Stall:** assert `stall` for 3 cycles with an instruction in EX -> `in_ready=0`, `alu_*` and `res_*` frozen, no write. On release the result retires exactly once.
